// File: rtl/ft_lockstep_monitor.sv
// Lockstep write-port monitor for 2 (DMR detect) or 3 (TMR vote) cores.
// Detects divergence, votes in TMR and sequences halt / recovery / core reset.
module ft_lockstep_monitor #(
  parameter int NCORES       = 2,
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int MAX_RETRIES  = 3,
  parameter int CLEAN_CYCLES = 1024,
  parameter int TIMEOUT      = 4096,
  parameter int RST_CYCLES   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [NCORES-1:0]    we_i,
  input  logic [NCORES*AW-1:0] waddr_i,
  input  logic [NCORES*DW-1:0] wdata_i,
  input  logic [DW-1:0]        pc_i,
  input  logic                 force_error_i,
  input  logic                 done_i,
  output logic                 vote_we_o,
  output logic [AW-1:0]        vote_waddr_o,
  output logic [DW-1:0]        vote_wdata_o,
  output logic                 error_o,
  output logic [1:0]           faulty_lane_o,
  output logic                 recover_o,
  output logic                 recovering_o,
  output logic                 reset_o,
  output logic                 fatal_o,
  output logic [DW-1:0]        ckpt_pc_o,
  output logic [15:0]          err_count_o
);
  localparam int KW = 1 + AW + DW;
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int CW = $clog2(CLEAN_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(RST_CYCLES + 1);

  if (NCORES != 2 && NCORES != 3) begin : g_bad_ncores
    $error("ft_lockstep_monitor: NCORES must be 2 or 3");
  end

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_RESET   = 2'd2,
    ST_FATAL   = 2'd3
  } state_t;

  // Lanes are always held three wide; an absent third lane stays zero.
  logic [2:0]      we_r;
  logic [3*AW-1:0] waddr_r;
  logic [3*DW-1:0] wdata_r;
  logic [DW-1:0]   pc_r;
  logic            en_r;
  logic            force_r;

  state_t          state_r;
  logic [RW-1:0]   retry_r;
  logic [CW-1:0]   clean_r;
  logic [TW-1:0]   tmo_r;
  logic [SW-1:0]   rst_cnt_r;
  logic            recover_r, recovering_r, reset_r, fatal_r;
  logic [DW-1:0]   ckpt_r;
  logic [15:0]     err_cnt_r;
  logic [1:0]      faulty_r;

  logic [KW-1:0]   key_s [3];
  logic [KW-1:0]   vkey_s;
  logic            cmp_active_s, clean_s, minor_s, major_s, error_s;
  logic            e01_s, e02_s, e12_s;
  logic [1:0]      vote_lane_s, bad_lane_s;

  // Stage 1: capture every lane's write port alongside the sample's enable and force.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_r    <= 3'b000;
      waddr_r <= '0;
      wdata_r <= '0;
      pc_r    <= '0;
      en_r    <= 1'b0;
      force_r <= 1'b0;
    end else begin
      we_r    <= 3'(we_i);
      waddr_r <= (3*AW)'(waddr_i);
      wdata_r <= (3*DW)'(wdata_i);
      pc_r    <= pc_i;
      en_r    <= enable_i;
      force_r <= force_error_i;
    end
  end

  // Lane keys (address/data masked when not writing) and fault classification.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      key_s[k] = we_r[k] ? {1'b1, waddr_r[k*AW +: AW], wdata_r[k*DW +: DW]} : '0;
    end
    e01_s        = (key_s[0] == key_s[1]);
    e02_s        = (key_s[0] == key_s[2]);
    e12_s        = (key_s[1] == key_s[2]);
    cmp_active_s = en_r && (state_r == ST_RUN);
    clean_s      = 1'b0;
    minor_s      = 1'b0;
    major_s      = 1'b0;
    vote_lane_s  = 2'd0;
    bad_lane_s   = 2'b11;
    if (!cmp_active_s) begin
      clean_s = 1'b0;
    end else if (force_r) begin
      major_s = 1'b1;
    end else if (NCORES == 2) begin
      if (e01_s) clean_s = 1'b1;
      else       major_s = 1'b1;
    end else begin
      if (e01_s && e02_s) begin
        clean_s = 1'b1;
      end else if (e01_s) begin
        minor_s = 1'b1; bad_lane_s = 2'd2;
      end else if (e02_s) begin
        minor_s = 1'b1; bad_lane_s = 2'd1;
      end else if (e12_s) begin
        minor_s = 1'b1; bad_lane_s = 2'd0; vote_lane_s = 2'd1;
      end else begin
        major_s = 1'b1;
      end
    end
  end

  // Voted write port: majority lane when outvoting, lane 0 otherwise.
  always_comb begin
    case (vote_lane_s)
      2'd1:    vkey_s = key_s[1];
      2'd2:    vkey_s = key_s[2];
      default: vkey_s = key_s[0];
    endcase
  end

  assign error_s       = minor_s | major_s;
  assign error_o       = error_s;
  assign vote_we_o     = vkey_s[KW-1];
  assign vote_waddr_o  = vkey_s[DW +: AW];
  assign vote_wdata_o  = vkey_s[DW-1:0];
  assign faulty_lane_o = minor_s ? bad_lane_s : faulty_r;

  // Recovery FSM with its counters and all registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_RUN;
      retry_r      <= '0;
      clean_r      <= '0;
      tmo_r        <= '0;
      rst_cnt_r    <= '0;
      recover_r    <= 1'b0;
      recovering_r <= 1'b0;
      reset_r      <= 1'b0;
      fatal_r      <= 1'b0;
      ckpt_r       <= '0;
      err_cnt_r    <= 16'h0000;
      faulty_r     <= 2'b11;
    end else begin
      if (error_s && err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'h0001;
      if (clean_s && we_r[0]) ckpt_r <= pc_r;
      if (minor_s) faulty_r <= bad_lane_s;
      case (state_r)
        ST_RUN: begin
          if (major_s) begin
            clean_r <= '0;
            if (retry_r == RW'(MAX_RETRIES)) begin
              state_r <= ST_FATAL;
              fatal_r <= 1'b1;
            end else begin
              state_r      <= ST_RECOVER;
              recover_r    <= 1'b1;
              recovering_r <= 1'b1;
              tmo_r        <= '0;
            end
          end else if (minor_s) begin
            clean_r <= '0;
          end else if (clean_r == CW'(CLEAN_CYCLES - 1)) begin
            clean_r <= '0;
            retry_r <= '0;
          end else begin
            clean_r <= clean_r + CW'(1);
          end
        end
        ST_RECOVER: begin
          // done_i has priority over an expiring timeout.
          if (done_i) begin
            retry_r   <= retry_r + RW'(1);
            state_r   <= ST_RESET;
            recover_r <= 1'b0;
            reset_r   <= 1'b1;
            rst_cnt_r <= '0;
          end else if (tmo_r == TW'(TIMEOUT - 1)) begin
            state_r      <= ST_FATAL;
            fatal_r      <= 1'b1;
            recover_r    <= 1'b0;
            recovering_r <= 1'b0;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_RESET: begin
          if (rst_cnt_r == SW'(RST_CYCLES - 1)) begin
            state_r      <= ST_RUN;
            reset_r      <= 1'b0;
            recovering_r <= 1'b0;
          end else begin
            rst_cnt_r <= rst_cnt_r + SW'(1);
          end
        end
        default: begin
          state_r      <= ST_FATAL;
          fatal_r      <= 1'b1;
          recover_r    <= 1'b0;
          recovering_r <= 1'b0;
          reset_r      <= 1'b0;
        end
      endcase
    end
  end

  assign recover_o    = recover_r;
  assign recovering_o = recovering_r;
  assign reset_o      = reset_r;
  assign fatal_o      = fatal_r;
  assign ckpt_pc_o    = ckpt_r;
  assign err_count_o  = err_cnt_r;
endmodule

// File: tb/tb_ft_lockstep_monitor.sv
// Scoreboard bench: a DMR and a TMR instance driven by directed vectors; expected
// values are queued per cycle and checked by an independent negedge monitor.
module tb_ft_lockstep_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  int   cyc = 0;

  logic [1:0]  d2_we = '0;
  logic [9:0]  d2_waddr = '0;
  logic [63:0] d2_wdata = '0;
  logic [31:0] d2_pc = '0;
  logic        d2_force = 1'b0, d2_done = 1'b0;
  logic        d2_vwe, d2_err, d2_rec, d2_recing, d2_rst, d2_fatal;
  logic [4:0]  d2_vwaddr;
  logic [31:0] d2_vwdata, d2_ckpt;
  logic [1:0]  d2_flt;
  logic [15:0] d2_cnt;

  logic [2:0]  d3_we = '0;
  logic [14:0] d3_waddr = '0;
  logic [95:0] d3_wdata = '0;
  logic [31:0] d3_pc = '0;
  logic        d3_force = 1'b0, d3_done = 1'b0;
  logic        d3_vwe, d3_err, d3_rec, d3_recing, d3_rst, d3_fatal;
  logic [4:0]  d3_vwaddr;
  logic [31:0] d3_vwdata, d3_ckpt;
  logic [1:0]  d3_flt;
  logic [15:0] d3_cnt;

  ft_lockstep_monitor #(.NCORES(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .we_i(d2_we), .waddr_i(d2_waddr),
    .wdata_i(d2_wdata), .pc_i(d2_pc), .force_error_i(d2_force), .done_i(d2_done),
    .vote_we_o(d2_vwe), .vote_waddr_o(d2_vwaddr), .vote_wdata_o(d2_vwdata), .error_o(d2_err),
    .faulty_lane_o(d2_flt), .recover_o(d2_rec), .recovering_o(d2_recing), .reset_o(d2_rst),
    .fatal_o(d2_fatal), .ckpt_pc_o(d2_ckpt), .err_count_o(d2_cnt));

  ft_lockstep_monitor #(.NCORES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .we_i(d3_we), .waddr_i(d3_waddr),
    .wdata_i(d3_wdata), .pc_i(d3_pc), .force_error_i(d3_force), .done_i(d3_done),
    .vote_we_o(d3_vwe), .vote_waddr_o(d3_vwaddr), .vote_wdata_o(d3_vwdata), .error_o(d3_err),
    .faulty_lane_o(d3_flt), .recover_o(d3_rec), .recovering_o(d3_recing), .reset_o(d3_rst),
    .fatal_o(d3_fatal), .ckpt_pc_o(d3_ckpt), .err_count_o(d3_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S2_ERR = 0, S2_REC = 1, S2_RST = 2, S2_FATAL = 3, S2_CKPT = 4,
                 S2_CNT = 5, S2_RECING = 6, S2_FLT = 7;
  localparam int S3_ERR = 10, S3_REC = 11, S3_FATAL = 12, S3_WADDR = 13, S3_FLT = 14,
                 S3_WDATA = 15, S3_CNT = 16, S3_CKPT = 17, S3_WE = 18;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S2_ERR:    return 32'(d2_err);
      S2_REC:    return 32'(d2_rec);
      S2_RST:    return 32'(d2_rst);
      S2_FATAL:  return 32'(d2_fatal);
      S2_CKPT:   return d2_ckpt;
      S2_CNT:    return 32'(d2_cnt);
      S2_RECING: return 32'(d2_recing);
      S2_FLT:    return 32'(d2_flt);
      S3_ERR:    return 32'(d3_err);
      S3_REC:    return 32'(d3_rec);
      S3_FATAL:  return 32'(d3_fatal);
      S3_WADDR:  return 32'(d3_vwaddr);
      S3_FLT:    return 32'(d3_flt);
      S3_WDATA:  return d3_vwdata;
      S3_CNT:    return 32'(d3_cnt);
      S3_CKPT:   return d3_ckpt;
      S3_WE:     return 32'(d3_vwe);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string name_of(int sel);
    case (sel)
      S2_ERR:    return "dmr_error";
      S2_REC:    return "dmr_recover";
      S2_RST:    return "dmr_reset";
      S2_FATAL:  return "dmr_fatal";
      S2_CKPT:   return "dmr_ckpt_pc";
      S2_CNT:    return "dmr_err_count";
      S2_RECING: return "dmr_recovering";
      S2_FLT:    return "dmr_faulty_lane";
      S3_ERR:    return "tmr_error";
      S3_REC:    return "tmr_recover";
      S3_FATAL:  return "tmr_fatal";
      S3_WADDR:  return "tmr_vote_waddr";
      S3_FLT:    return "tmr_faulty_lane";
      S3_WDATA:  return "tmr_vote_wdata";
      S3_CNT:    return "tmr_err_count";
      S3_CKPT:   return "tmr_ckpt_pc";
      S3_WE:     return "tmr_vote_we";
      default:   return "unknown";
    endcase
  endfunction

  // Monitor: pops every expectation that falls due this cycle and compares.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = obs(e.sel);
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s missed its cycle %0d (now %0d)", name_of(e.sel), e.cyc, cyc);
      end else if (a !== e.val) begin
        n_bad++;
        $display("FAIL %s cyc=%0d actual=%0h required=%0h", name_of(e.sel), cyc, a, e.val);
      end
    end
  end

  task automatic expect_at(int dcyc, int sel, logic [31:0] val);
    exp_t e;
    e.cyc = cyc + dcyc;
    e.sel = sel;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_both();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    // Reset values
    repeat (3) step();
    expect_at(0, S2_ERR, 32'd0);
    expect_at(0, S2_REC, 32'd0);
    expect_at(0, S2_RST, 32'd0);
    expect_at(0, S2_FATAL, 32'd0);
    expect_at(0, S2_CKPT, 32'd0);
    expect_at(0, S2_CNT, 32'd0);
    expect_at(0, S2_FLT, 32'd3);
    expect_at(0, S3_FLT, 32'd3);
    step();
    rst_n = 1'b1;
    enable = 1'b1;
    step();

    // T1: DMR matched commit updates the checkpoint
    d2_we = 2'b11; d2_waddr = {5'd5, 5'd5}; d2_wdata = {32'h1234, 32'h1234}; d2_pc = 32'h80;
    expect_at(1, S2_ERR, 32'd0);
    expect_at(2, S2_CKPT, 32'h80);
    expect_at(2, S2_REC, 32'd0);
    step();
    d2_we = 2'b00;
    repeat (2) step();

    // T2: DMR data divergence -> recovery sequence
    d2_we = 2'b11; d2_wdata = {32'h1235, 32'h1234}; d2_pc = 32'h84;
    expect_at(1, S2_ERR, 32'd1);
    expect_at(1, S2_REC, 32'd0);
    expect_at(2, S2_REC, 32'd1);
    expect_at(2, S2_RECING, 32'd1);
    expect_at(2, S2_CNT, 32'd1);
    expect_at(2, S2_CKPT, 32'h80);
    step();
    d2_we = 2'b00;
    repeat (4) step();
    expect_at(0, S2_REC, 32'd1);
    d2_done = 1'b1;
    expect_at(1, S2_RST, 32'd1);
    expect_at(1, S2_REC, 32'd0);
    expect_at(4, S2_RST, 32'd1);
    expect_at(5, S2_RST, 32'd0);
    expect_at(5, S2_RECING, 32'd0);
    step();
    d2_done = 1'b0;
    repeat (6) step();

    // T3: TMR lane 2 address outvoted, no recovery
    d3_we = 3'b111; d3_waddr = {5'd6, 5'd5, 5'd5}; d3_wdata = {3{32'hABCD}}; d3_pc = 32'h100;
    expect_at(1, S3_ERR, 32'd1);
    expect_at(1, S3_WADDR, 32'd5);
    expect_at(1, S3_FLT, 32'd2);
    expect_at(1, S3_WE, 32'd1);
    expect_at(2, S3_REC, 32'd0);
    expect_at(2, S3_CNT, 32'd1);
    expect_at(2, S3_CKPT, 32'd0);
    step();
    d3_waddr = {5'd7, 5'd7, 5'd7}; d3_wdata = {3{32'h5555}}; d3_pc = 32'h104;
    expect_at(1, S3_ERR, 32'd0);
    expect_at(1, S3_WDATA, 32'h5555);
    expect_at(1, S3_FLT, 32'd2);
    expect_at(2, S3_CKPT, 32'h104);
    expect_at(2, S3_REC, 32'd0);
    step();
    d3_wdata = {32'h9, 32'h9, 32'h8};
    expect_at(1, S3_ERR, 32'd1);
    expect_at(1, S3_WDATA, 32'h9);
    expect_at(1, S3_FLT, 32'd0);
    expect_at(2, S3_CNT, 32'd2);
    step();
    d3_we = 3'b000;
    repeat (3) step();

    // T4: TMR triple divergence, done withheld -> timeout to sticky FATAL
    d3_we = 3'b111; d3_wdata = {32'h3, 32'h2, 32'h1};
    expect_at(1, S3_ERR, 32'd1);
    expect_at(2, S3_REC, 32'd1);
    expect_at(2, S3_CNT, 32'd3);
    step();
    d3_we = 3'b000;
    repeat (4090) step();
    expect_at(6, S3_FATAL, 32'd0);
    expect_at(6, S3_REC, 32'd1);
    expect_at(7, S3_FATAL, 32'd1);
    expect_at(7, S3_REC, 32'd0);
    repeat (10) step();
    d3_done = 1'b1;
    expect_at(2, S3_FATAL, 32'd1);
    expect_at(2, S3_REC, 32'd0);
    step();
    d3_done = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    expect_at(0, S3_FATAL, 32'd0);
    expect_at(0, S3_FLT, 32'd3);
    step();
    rst_n = 1'b1;
    step();

    // Compare disabled: no error, vote follows lane 0
    enable = 1'b0;
    d3_we = 3'b111; d3_wdata = {32'h3, 32'h2, 32'h1};
    expect_at(1, S3_ERR, 32'd0);
    expect_at(1, S3_WDATA, 32'h1);
    expect_at(2, S3_REC, 32'd0);
    step();
    d3_we = 3'b000;
    step();
    enable = 1'b1;
    step();

    // T5a: four forced errors inside one window -> fourth is FATAL
    for (int i = 0; i < 4; i++) begin
      d2_force = 1'b1;
      expect_at(1, S2_ERR, 32'd1);
      if (i < 3) begin
        expect_at(2, S2_REC, 32'd1);
      end else begin
        expect_at(2, S2_FATAL, 32'd1);
        expect_at(2, S2_REC, 32'd0);
      end
      step();
      d2_force = 1'b0;
      if (i < 3) begin
        repeat (3) step();
        d2_done = 1'b1;
        step();
        d2_done = 1'b0;
        repeat (6) step();
      end else begin
        repeat (3) step();
      end
    end
    reset_both();

    // T5b: clean windows between errors keep clearing the retry budget
    for (int i = 0; i < 4; i++) begin
      repeat (1100) step();
      d2_force = 1'b1;
      expect_at(1, S2_ERR, 32'd1);
      expect_at(2, S2_REC, 32'd1);
      expect_at(2, S2_FATAL, 32'd0);
      step();
      d2_force = 1'b0;
      repeat (3) step();
      d2_done = 1'b1;
      step();
      d2_done = 1'b0;
      repeat (6) step();
    end

    // T6: async reset in the middle of RESET
    d2_force = 1'b1;
    step();
    d2_force = 1'b0;
    repeat (3) step();
    d2_done = 1'b1;
    step();
    d2_done = 1'b0;
    expect_at(0, S2_RST, 32'd1);
    step();
    rst_n = 1'b0;
    expect_at(0, S2_RST, 32'd0);
    expect_at(0, S2_RECING, 32'd0);
    expect_at(0, S2_REC, 32'd0);
    expect_at(0, S2_CNT, 32'd0);
    expect_at(0, S2_FLT, 32'd3);
    step();
    rst_n = 1'b1;
    step();
    d2_we = 2'b00; d2_waddr = {5'd3, 5'd7}; d2_wdata = {32'h1, 32'h2};
    d3_we = 3'b000; d3_waddr = {5'd1, 5'd2, 5'd3}; d3_wdata = {32'h4, 32'h5, 32'h6};
    expect_at(1, S2_ERR, 32'd0);
    expect_at(1, S3_ERR, 32'd0);
    expect_at(2, S2_REC, 32'd0);
    expect_at(2, S2_CNT, 32'd0);
    expect_at(2, S3_CNT, 32'd0);
    repeat (3) step();

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 50 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
